// File: rtl/snake_game_ctrl_if.sv
// Board/core-facing signals of snake_game_ctrl.
// master: the controller; slave: buttons and snake core.
interface snake_game_ctrl_if;
  logic        btn_center;
  logic        btn_pause;
  logic        fruit_eaten;
  logic        collision;
  logic        step_tick;
  logic        restart;
  logic [1:0]  state;
  logic [7:0]  score;
  logic [3:0]  level;
  logic [26:0] interval;

  modport master (
    input  btn_center,
    input  btn_pause,
    input  fruit_eaten,
    input  collision,
    output step_tick,
    output restart,
    output state,
    output score,
    output level,
    output interval
  );

  modport slave (
    output btn_center,
    output btn_pause,
    output fruit_eaten,
    output collision,
    input  step_tick,
    input  restart,
    input  state,
    input  score,
    input  level,
    input  interval
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game-flow FSM, button debounce and step scheduler.
// Ports: clk, rst (sync, active-high), bus (master):
//   in  btn_center, btn_pause, fruit_eaten, collision
//   out step_tick, restart, state, score, level, interval
// SNAKE_PAUSE_EN: builds the pause button path and PAUSE.
module snake_game_ctrl #(
  parameter int BASE_INTERVAL    = 100_000_000,
  parameter int MIN_INTERVAL     = 25_000_000,
  parameter int SPEEDUP_STEP     = 5_000_000,
  parameter int FRUITS_PER_LEVEL = 4,
  parameter int DEBOUNCE_CYCLES  = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  snake_game_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam int FW =
    (FRUITS_PER_LEVEL > 1) ? $clog2(FRUITS_PER_LEVEL) : 1;
  localparam logic [FW-1:0] FR_LAST =
    FW'(FRUITS_PER_LEVEL - 1);
  localparam logic [26:0] BASE_IV = 27'(BASE_INTERVAL);

  // Done at 32 bits so a large level cannot wrap below MIN.
  function automatic logic [26:0] f_interval(
    input logic [3:0] lvl
  );
    logic [31:0] w_dec;
    w_dec = 32'(lvl) * 32'(SPEEDUP_STEP);
    if (w_dec >= 32'(BASE_INTERVAL) - 32'(MIN_INTERVAL))
      return 27'(MIN_INTERVAL);
    return 27'(32'(BASE_INTERVAL) - w_dec);
  endfunction

  logic          r_c_s1, r_c_s2;
  logic          r_c_db, r_c_db_q;
  logic [CW-1:0] r_c_cnt;
  logic          w_c_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_s1   <= 1'b0;
      r_c_s2   <= 1'b0;
      r_c_db   <= 1'b0;
      r_c_db_q <= 1'b0;
      r_c_cnt  <= '0;
    end else begin
      r_c_s1   <= bus.btn_center;
      r_c_s2   <= r_c_s1;
      r_c_db_q <= r_c_db;
      if (r_c_s2 == r_c_db) begin
        r_c_cnt <= '0;
      end else if (r_c_cnt == DB_LAST) begin
        r_c_db  <= r_c_s2;
        r_c_cnt <= '0;
      end else begin
        r_c_cnt <= r_c_cnt + 1'b1;
      end
    end
  end

  assign w_c_press = r_c_db & ~r_c_db_q;

  logic w_p_press;

`ifdef SNAKE_PAUSE_EN
  logic          r_p_s1, r_p_s2;
  logic          r_p_db, r_p_db_q;
  logic [CW-1:0] r_p_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_s1   <= 1'b0;
      r_p_s2   <= 1'b0;
      r_p_db   <= 1'b0;
      r_p_db_q <= 1'b0;
      r_p_cnt  <= '0;
    end else begin
      r_p_s1   <= bus.btn_pause;
      r_p_s2   <= r_p_s1;
      r_p_db_q <= r_p_db;
      if (r_p_s2 == r_p_db) begin
        r_p_cnt <= '0;
      end else if (r_p_cnt == DB_LAST) begin
        r_p_db  <= r_p_s2;
        r_p_cnt <= '0;
      end else begin
        r_p_cnt <= r_p_cnt + 1'b1;
      end
    end
  end

  assign w_p_press = r_p_db & ~r_p_db_q;
`else
  assign w_p_press = 1'b0;
`endif

  state_t        r_state;
  logic          r_tick;
  logic          r_restart;
  logic [7:0]    r_score;
  logic [3:0]    r_level;
  logic [26:0]   r_interval;
  logic [26:0]   r_timer;
  logic [FW-1:0] r_fruit;

  logic       w_expire;
  logic [3:0] w_lvl_inc;

  assign w_expire  = (r_timer >= r_interval - 27'd1);
  assign w_lvl_inc =
    (r_level == 4'hF) ? r_level : r_level + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick     <= 1'b0;
      r_restart  <= 1'b0;
      r_score    <= '0;
      r_level    <= '0;
      r_interval <= BASE_IV;
      r_timer    <= '0;
      r_fruit    <= '0;
    end else begin
      r_tick    <= 1'b0;
      r_restart <= 1'b0;
      if (w_c_press) begin
        r_state    <= S_RUN;
        r_restart  <= 1'b1;
        r_score    <= '0;
        r_level    <= '0;
        r_interval <= BASE_IV;
        r_timer    <= '0;
        r_fruit    <= '0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (bus.collision) begin
              r_state <= S_OVER;
            end else if (w_p_press) begin
              r_state <= S_PAUSE;
            end else begin
              if (bus.fruit_eaten) begin
                if (r_score != 8'hFF)
                  r_score <= r_score + 8'd1;
                if (r_fruit == FR_LAST) begin
                  r_fruit    <= '0;
                  r_level    <= w_lvl_inc;
                  r_interval <= f_interval(w_lvl_inc);
                end else begin
                  r_fruit <= r_fruit + 1'b1;
                end
              end
              if (w_expire) begin
                r_tick  <= 1'b1;
                r_timer <= '0;
              end else begin
                r_timer <= r_timer + 27'd1;
              end
            end
          end
          S_PAUSE: begin
            if (w_p_press)
              r_state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.step_tick = r_tick;
  assign bus.restart   = r_restart;
  assign bus.state     = r_state;
  assign bus.score     = r_score;
  assign bus.level     = r_level;
  assign bus.interval  = r_interval;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl.
// Small parameters: base 20, min 8, step 4, 2 fruits, debounce 3.
module tb_snake_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_game_ctrl_if ifc ();

  snake_game_ctrl #(
    .BASE_INTERVAL    (20),
    .MIN_INTERVAL     (8),
    .SPEEDUP_STEP     (4),
    .FRUITS_PER_LEVEL (2),
    .DEBOUNCE_CYCLES  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int tick_q[$];
  int rst_q[$];

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc1;
    @(negedge clk);
    cyc++;
    if (ifc.step_tick) tick_q.push_back(cyc);
    if (ifc.restart) rst_q.push_back(cyc);
  endtask

  function automatic int tick_at(input int i);
    if (i < tick_q.size()) return tick_q[i];
    return -1;
  endfunction

  function automatic int rst_at(input int i);
    if (i < rst_q.size()) return rst_q[i];
    return -1;
  endfunction

  task automatic wait_tick(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      cyc1();
      if (ifc.step_tick) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk({tag, "_tick_timeout"}, t, cyc);
  endtask

  task automatic fruit1;
    ifc.fruit_eaten = 1'b1;
    cyc1();
    ifc.fruit_eaten = 1'b0;
  endtask

  task automatic press_center(output int nres, output int st,
                              output int sc, output int lv,
                              output int iv);
    int n0;
    n0 = rst_q.size();
    st = -1; sc = -1; lv = -1; iv = -1;
    ifc.btn_center = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc1();
      if (ifc.restart) begin
        st = int'(ifc.state);
        sc = int'(ifc.score);
        lv = int'(ifc.level);
        iv = int'(ifc.interval);
      end
    end
    ifc.btn_center = 1'b0;
    repeat (8) cyc1();
    nres = rst_q.size() - n0;
  endtask

  task automatic chk_restart(input string tag);
    int nr, st, sc, lv, iv;
    press_center(nr, st, sc, lv, iv);
    chk({tag, "_n_restart"}, nr, 1);
    chk({tag, "_state"}, st, 1);
    chk({tag, "_score"}, sc, 0);
    chk({tag, "_level"}, lv, 0);
    chk({tag, "_interval"}, iv, 20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int c0, t, t1, t2, c2;
    int exp_iv [4] = '{16, 12, 8, 8};
    int exp_pst, exp_first;

    ifc.btn_center  = 1'b0;
    ifc.btn_pause   = 1'b0;
    ifc.fruit_eaten = 1'b0;
    ifc.collision   = 1'b0;

    rst = 1'b1;
    repeat (3) cyc1();
    chk("rst_state", int'(ifc.state), 0);
    chk("rst_tick", int'(ifc.step_tick), 0);
    chk("rst_restart", int'(ifc.restart), 0);
    chk("rst_score", int'(ifc.score), 0);
    chk("rst_level", int'(ifc.level), 0);
    chk("rst_interval", int'(ifc.interval), 20);
    rst = 1'b0;
    repeat (2) cyc1();

    // 2-cycle glitch must not pass the debouncer
    rst_q.delete();
    ifc.btn_center = 1'b1;
    repeat (2) cyc1();
    ifc.btn_center = 1'b0;
    repeat (20) cyc1();
    chk("glitch_n_restart", rst_q.size(), 0);
    chk("glitch_state", int'(ifc.state), 0);

    // 10-cycle press from IDLE
    rst_q.delete();
    tick_q.delete();
    c0 = cyc;
    ifc.btn_center = 1'b1;
    repeat (10) cyc1();
    ifc.btn_center = 1'b0;
    repeat (60) cyc1();
    chk("start_n_restart", rst_q.size(), 1);
    chk("start_restart_cyc", rst_at(0) - c0, 6);
    chk("start_state", int'(ifc.state), 1);
    chk("start_tick0", tick_at(0) - rst_at(0), 20);
    chk("start_tick1", tick_at(1) - tick_at(0), 20);
    chk("start_tick2", tick_at(2) - tick_at(1), 20);

    // fruit pairs raise the level and shorten the period
    for (int k = 0; k < 4; k++) begin
      wait_tick("fruit_sync", t);
      fruit1();
      fruit1();
      chk($sformatf("fruit%0d_score", k),
          int'(ifc.score), 2 * (k + 1));
      chk($sformatf("fruit%0d_level", k),
          int'(ifc.level), k + 1);
      chk($sformatf("fruit%0d_interval", k),
          int'(ifc.interval), exp_iv[k]);
      wait_tick("fruit_t1", t1);
      wait_tick("fruit_t2", t2);
      chk($sformatf("fruit%0d_spacing", k),
          t2 - t1, exp_iv[k]);
    end

    // collision + fruit on the expiry cycle (interval 8)
    wait_tick("coll_sync", t);
    repeat (7) cyc1();
    ifc.collision   = 1'b1;
    ifc.fruit_eaten = 1'b1;
    cyc1();
    ifc.collision   = 1'b0;
    ifc.fruit_eaten = 1'b0;
    chk("coll_state", int'(ifc.state), 3);
    chk("coll_score", int'(ifc.score), 8);
    chk("coll_tick", int'(ifc.step_tick), 0);
    tick_q.delete();
    repeat (100) cyc1();
    chk("over_n_ticks", tick_q.size(), 0);
    chk("over_state", int'(ifc.state), 3);
    chk("over_level", int'(ifc.level), 4);

    chk_restart("rs_from_over8");

    // second game: 5 fruits then collision, then restart
    repeat (5) fruit1();
    chk("g2_score", int'(ifc.score), 5);
    chk("g2_level", int'(ifc.level), 2);
    chk("g2_interval", int'(ifc.interval), 12);
    ifc.collision = 1'b1;
    cyc1();
    ifc.collision = 1'b0;
    chk("g2_over_state", int'(ifc.state), 3);
    repeat (10) cyc1();
    chk("g2_over_score", int'(ifc.score), 5);
    chk_restart("rs_from_over5");

    // pause at timer=7, hold 50 cycles, pause again
`ifdef SNAKE_PAUSE_EN
    exp_pst = 2;
`else
    exp_pst = 1;
`endif
    wait_tick("pause_sync", t);
    tick_q.delete();
    repeat (2) cyc1();
    ifc.btn_pause = 1'b1;
    repeat (6) cyc1();
    chk("pause_state", int'(ifc.state), exp_pst);
    repeat (44) cyc1();
    ifc.btn_pause = 1'b0;
    repeat (10) cyc1();
    c2 = cyc;
    ifc.btn_pause = 1'b1;
    repeat (8) cyc1();
    ifc.btn_pause = 1'b0;
    repeat (20) cyc1();
`ifdef SNAKE_PAUSE_EN
    exp_first = c2 + 6 + 13;
`else
    exp_first = t + 20;
`endif
    chk("pause_first_tick", tick_at(0), exp_first);
    chk("pause_resume_state", int'(ifc.state), 1);

    // reset in the middle of a game
    fruit1();
    chk("pre_rst_score", int'(ifc.score), 1);
    rst = 1'b1;
    cyc1();
    rst = 1'b0;
    chk("mid_rst_state", int'(ifc.state), 0);
    chk("mid_rst_score", int'(ifc.score), 0);
    chk("mid_rst_interval", int'(ifc.interval), 20);
    chk("mid_rst_tick", int'(ifc.step_tick), 0);
    chk("mid_rst_restart", int'(ifc.restart), 0);
    tick_q.delete();
    repeat (40) cyc1();
    chk("idle_n_ticks", tick_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
